// File: rtl/key_filter_if.sv
// Debounced key interface: key_filter drives it (master), LED/counter control blocks read it (slave).
// key_flag is a one-cycle strobe with no ready/back-pressure; key_state is always valid; key_long is a one-cycle strobe.
interface key_filter_if;
  logic key_flag;
  logic key_state;
  logic key_long;

  modport master (output key_flag, key_state, key_long);
  modport slave  (input  key_flag, key_state, key_long);
endinterface

// File: rtl/key_filter.sv
// Active-low push-button debouncer: 2-flop synchronizer, 4-state filter FSM, registered flag/level outputs.
// Optional long-press pulse is built only when KEY_LONG_PRESS_EN is defined; otherwise key_long is tied to 0.
module key_filter #(
  parameter int unsigned CNT_MAX  = 999_999,
  parameter int unsigned LONG_MAX = 49_999_999
) (
  input  logic               clk_50mhz,
  input  logic               rst,
  input  logic               key_in,
  key_filter_if.master       key_o,
  output logic [1:0]         state_dbg_o
);

  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    FILTER_DOWN = 2'd1,
    DOWN        = 2'd2,
    FILTER_UP   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             key_sync;
  logic             key_flag_q, key_flag_d;
  logic             key_state_q, key_state_d;

  assign key_sync = sync2_q;

  // The stable level follows the FSM one cycle late, so the flag is simply "level about to change".
  assign key_state_d = (state_q == IDLE) || (state_q == FILTER_DOWN);
  assign key_flag_d  = key_state_d ^ key_state_q;

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_flag_q  <= 1'b0;
      key_state_q <= 1'b1;
    end else begin
      sync1_q     <= key_in;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_flag_q  <= key_flag_d;
      key_state_q <= key_state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (!key_sync) begin
          state_d = FILTER_DOWN;
          cnt_d   = '0;
        end
      end
      FILTER_DOWN: begin
        if (key_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DOWN: begin
        if (key_sync) begin
          state_d = FILTER_UP;
          cnt_d   = '0;
        end
      end
      FILTER_UP: begin
        if (!key_sync) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_W = $clog2(LONG_MAX + 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX);

  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              fired_q, fired_d;
  logic              key_long_q, key_long_d;

  // Re-arm on the press-flag cycle (DOWN with the old released level), which only follows FILTER_DOWN;
  // a bounce back from FILTER_UP finds key_state already 0 and just resumes the paused count.
  always_comb begin
    long_cnt_d = long_cnt_q;
    fired_d    = fired_q;
    key_long_d = 1'b0;
    if (state_q == DOWN && key_state_q) begin
      long_cnt_d = '0;
      fired_d    = 1'b0;
    end else if (state_q == DOWN && !fired_q) begin
      if (long_cnt_q == LONG_LAST) begin
        key_long_d = 1'b1;
        fired_d    = 1'b1;
      end else begin
        long_cnt_d = long_cnt_q + LONG_W'(1);
      end
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      long_cnt_q <= '0;
      fired_q    <= 1'b0;
      key_long_q <= 1'b0;
    end else begin
      long_cnt_q <= long_cnt_d;
      fired_q    <= fired_d;
      key_long_q <= key_long_d;
    end
  end

  assign key_o.key_long = key_long_q;
`else
  logic unused_long_max;
  assign unused_long_max = |LONG_MAX;
  assign key_o.key_long  = 1'b0;
`endif

  assign key_o.key_flag  = key_flag_q;
  assign key_o.key_state = key_state_q;
  assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter: window-based level model with per-cycle scoreboard plus literal latency pins.
`timescale 1ns/1ps
module tb_key_filter;
  localparam int CNT_MAX  = 9;
  localparam int LONG_MAX = 29;
  localparam int LAT      = 13;   // CNT_MAX + 4, hand-computed
  localparam int LONG_LAT = 43;   // LAT + LONG_MAX + 1, hand-computed
  localparam int WIN      = CNT_MAX + 2;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_in = 1'b1;
  logic [1:0] state_dbg;

  key_filter_if kif();

  key_filter #(.CNT_MAX(CNT_MAX), .LONG_MAX(LONG_MAX)) dut (
    .clk_50mhz   (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_o       (kif.master),
    .state_dbg_o (state_dbg)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- model ----------------
  // Level flips when the last WIN raw samples (ending 3 edges ago) all disagree with it.
  logic [2:0] exp_q[$];
  logic       hist[$];
  logic       m_level = 1'b1;
  int         long_due = -1;
  int         m_flag_cyc = -1;

  always @(posedge clk) begin
    logic hit;
    logic nlong;
    cyc++;
    if (rst) begin
      hist = {};
      for (int i = 0; i < 64; i++) hist.push_back(1'b1);
      m_level  = 1'b1;
      long_due = -1;
      exp_q.push_back(3'b010);
    end else begin
      hist.push_back(key_in);
      if (hist.size() > 64) void'(hist.pop_front());
      hit = 1'b1;
      for (int k = 0; k < WIN; k++)
        if (hist[hist.size() - 4 - k] == m_level) hit = 1'b0;
      if (hit) begin
        m_level    = ~m_level;
        m_flag_cyc = cyc;
        long_due   = m_level ? -1 : cyc + LONG_MAX + 1;
      end
      nlong = 1'b0;
      if (long_due == cyc) begin
`ifdef KEY_LONG_PRESS_EN
        nlong = 1'b1;
`endif
        long_due = -1;
      end
      exp_q.push_back({hit, m_level, nlong});
    end
  end

  // ---------------- scoreboard compare ----------------
  int dut_flag_n = 0;
  int dut_flag_cyc = -1;
  int dut_long_n = 0;
  int dut_long_cyc = -1;

  always @(negedge clk) begin
    logic [2:0] act;
    logic [2:0] exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {kif.key_flag, kif.key_state, kif.key_long};
      checks++;
      if (act !== exp) begin
        failures++;
        $display("FAIL cycle_out flag/state/long actual=%b required=%b (cycle %0d)", act, exp, cyc);
      end
      if (kif.key_flag) begin dut_flag_n++; dut_flag_cyc = cyc; end
      if (kif.key_long) begin dut_long_n++; dut_long_cyc = cyc; end
    end
  end

  // ---------------- drivers ----------------
  // Called at a negedge: v is sampled on the next n rising edges; t is the first of them.
  task automatic drive(input logic v, input int n, output int t);
    key_in = v;
    t = cyc + 1;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int t, t0, n0, l0;

  initial begin
    @(negedge clk);
    do_reset(3);
    chk("reset_flag", int'(kif.key_flag), 0);
    chk("reset_state", int'(kif.key_state), 1);
    chk("reset_long", int'(kif.key_long), 0);
    drive(1'b1, 5, t);

    // clean press held 100 cycles
    n0 = dut_flag_n; l0 = dut_long_n;
    drive(1'b0, 100, t0);
    chk("press_lat_dut", dut_flag_cyc, t0 + LAT);
    chk("press_lat_model", m_flag_cyc, t0 + LAT);
    chk("press_once", dut_flag_n - n0, 1);
    chk("press_state", int'(kif.key_state), 0);
`ifdef KEY_LONG_PRESS_EN
    chk("long_lat", dut_long_cyc, t0 + LONG_LAT);
    chk("long_once", dut_long_n - l0, 1);
`else
    chk("long_off", dut_long_n - l0, 0);
`endif

    // clean release
    n0 = dut_flag_n;
    drive(1'b1, 40, t0);
    chk("release_lat", dut_flag_cyc, t0 + LAT);
    chk("release_once", dut_flag_n - n0, 1);
    chk("release_state", int'(kif.key_state), 1);

    // bouncy press: low 5, high 2, then low held
    n0 = dut_flag_n;
    drive(1'b0, 5, t);
    drive(1'b1, 2, t);
    drive(1'b0, 60, t0);
    chk("bounce_lat", dut_flag_cyc, t0 + LAT);
    chk("bounce_once", dut_flag_n - n0, 1);
    drive(1'b1, 40, t);

    // glitch shorter than the window
    n0 = dut_flag_n;
    drive(1'b0, 8, t);
    drive(1'b1, 40, t);
    chk("glitch_noflag", dut_flag_n - n0, 0);
    chk("glitch_state", int'(kif.key_state), 1);

    // reset while FILTER_DOWN holds cnt=5, key kept low
    n0 = dut_flag_n;
    drive(1'b0, 8, t0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_flag", int'(kif.key_flag), 0);
    chk("rst_mid_state", int'(kif.key_state), 1);
    repeat (60) @(negedge clk);
    chk("rst_mid_relat", dut_flag_cyc, t0 + 9 + LAT);
    chk("rst_mid_once", dut_flag_n - n0, 1);
    drive(1'b1, 40, t);

    // fast toggling while released, then while pressed
    n0 = dut_flag_n;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 4, t);
      drive(1'b1, 4, t);
    end
    chk("toggle_rel_noflag", dut_flag_n - n0, 0);
    chk("toggle_rel_state", int'(kif.key_state), 1);
    drive(1'b0, 60, t);
    n0 = dut_flag_n;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 4, t);
      drive(1'b0, 4, t);
    end
    chk("toggle_prs_noflag", dut_flag_n - n0, 0);
    chk("toggle_prs_state", int'(kif.key_state), 0);
    drive(1'b1, 40, t);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
